// File: rtl/fifo_port_ctrl.sv
// fifo_port_ctrl: half-duplex FIFO port controller with guarded direction turnaround,
// zero-latency TX pass-through and a 2-entry registered RX output buffer.
module fifo_port_ctrl #(
    parameter int DSIZE       = 8,
    parameter int TURN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir_req,
    output logic             dir,
    output logic             busy,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic             fifo_winc,
    output logic [DSIZE-1:0] fifo_wdata,
    input  logic             fifo_full,
    output logic             fifo_rinc,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_empty,
    output logic [15:0]      tx_count,
    output logic [15:0]      rx_count
);
    typedef enum logic [1:0] {RX, TURN_R2T, TX, TURN_T2R} state_t;

    state_t           state_q, state_d;
    logic [7:0]       guard_q, guard_d;
    logic             inflight_q;
    logic [1:0]       occ_q, occ_d, base;
    logic [DSIZE-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
    logic [15:0]      tx_q, rx_q;
    logic             pop, room;

    assign dir        = (state_q == TX) || (state_q == TURN_T2R);
    assign busy       = (state_q == TURN_R2T) || (state_q == TURN_T2R);
    assign s_ready    = rst_n && (state_q == TX) && dir_req && !fifo_full;
    assign fifo_winc  = s_valid && s_ready;
    assign fifo_wdata = s_data;
    assign m_valid    = occ_q != 2'd0;
    assign m_data     = buf0_q;
    assign pop        = m_valid && m_ready;
    assign tx_count   = tx_q;
    assign rx_count   = rx_q;
    // Occupancy counted after this cycle's pop so a draining consumer keeps 1 word/cycle.
    assign room       = ({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
    assign fifo_rinc  = rst_n && (state_q == RX) && !fifo_empty && !dir_req && room;

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            RX: if (dir_req && !inflight_q && occ_q == 2'd0) begin
                state_d = TURN_R2T;
                guard_d = TURN_CYCLES[7:0];
            end
            TX: if (!dir_req) begin
                state_d = TURN_T2R;
                guard_d = TURN_CYCLES[7:0];
            end
            default: begin
                if (guard_q == 8'd0) state_d = (state_q == TURN_R2T) ? TX : RX;
                else guard_d = guard_q - 8'd1;
            end
        endcase
    end

    always_comb begin
        base   = occ_q - {1'b0, pop};
        occ_d  = base + {1'b0, inflight_q};
        buf0_d = pop ? buf1_q : buf0_q;
        buf1_d = buf1_q;
        if (inflight_q && base == 2'd0) buf0_d = fifo_rdata;
        if (inflight_q && base != 2'd0) buf1_d = fifo_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX;
            guard_q    <= 8'd0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            tx_q       <= 16'd0;
            rx_q       <= 16'd0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            inflight_q <= fifo_rinc;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            if (fifo_winc) tx_q <= tx_q + 16'd1;
            if (pop) rx_q <= rx_q + 16'd1;
        end
    end
endmodule

// File: doc/fifo_port_ctrl.md
FIFO_PORT_CTRL -- requirements
Module: fifo_port_ctrl

Interface
REQ-001 The module SHALL have parameter DSIZE, default 8, meaning the FIFO word width.
REQ-002 The module SHALL have parameter TURN_CYCLES, default 4, range 0-255, meaning the direction-turnaround guard length.
REQ-003 The module SHALL have port clk  input  1  the single clock for all logic.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port dir_req  input  1  requested direction: 1 = write (TX), 0 = read (RX).
REQ-006 The module SHALL have port dir  output  1  committed direction, driving the FIFO side's dir input.
REQ-007 The module SHALL have port busy  output  1  turnaround in progress.
REQ-008 The module SHALL have ports s_valid (input, 1), s_data (input, DSIZE) and s_ready (output, 1): the TX stream from the local master.
REQ-009 The module SHALL have ports m_valid (output, 1), m_data (output, DSIZE) and m_ready (input, 1): the RX stream to the local consumer.
REQ-010 The module SHALL have ports fifo_winc (output, 1), fifo_wdata (output, DSIZE) and fifo_full (input, 1): the FIFO write side.
REQ-011 The module SHALL have ports fifo_rinc (output, 1), fifo_rdata (input, DSIZE) and fifo_empty (input, 1): the FIFO read side.
REQ-012 The module SHALL have ports tx_count (output, 16) and rx_count (output, 16): words written and words delivered.

Function
REQ-013 The FSM SHALL have four states: RX, TURN_R2T, TX and TURN_T2R.
REQ-014 dir SHALL be 1 exactly when the state is TX or TURN_T2R; busy SHALL be 1 exactly when the state is TURN_R2T or TURN_T2R.
REQ-015 In TX, s_ready SHALL be combinationally equal to (!fifo_full && dir_req); in all other states it SHALL be 0.
REQ-016 fifo_winc SHALL equal s_valid && s_ready, and fifo_wdata SHALL equal s_data, with zero latency.
REQ-017 In RX, fifo_rinc SHALL be asserted when all three hold: !fifo_empty, dir_req == 0, and (buffered words + in-flight reads) < 2.
REQ-018 fifo_rdata SHALL be captured exactly 1 cycle after its fifo_rinc into a 2-entry output buffer, with FIFO order preserved.
REQ-019 m_valid SHALL be 1 whenever the output buffer is non-empty; m_data SHALL be the oldest entry, registered.
REQ-020 A pop SHALL occur on m_valid && m_ready; a simultaneous capture and pop SHALL keep the occupancy unchanged.
REQ-021 Across RX bursts with m_ready held high, the RX path SHALL sustain 1 word per cycle.
REQ-022 RX -> TURN_R2T SHALL occur when dir_req == 1, no read is in flight and the output buffer is empty; on entry the guard counter SHALL load TURN_CYCLES.
REQ-023 TX -> TURN_T2R SHALL occur when dir_req == 0; on entry the guard counter SHALL load TURN_CYCLES.
REQ-024 While in a TURN state, the guard counter SHALL decrement each cycle; the state SHALL exit when the counter reads 0, so a turnaround lasts TURN_CYCLES+1 cycles.
REQ-025 TURN_R2T SHALL exit to TX and TURN_T2R SHALL exit to RX.
REQ-026 A change of dir_req during a TURN state SHALL NOT abort the turnaround; dir_req SHALL be re-evaluated in the destination state.
REQ-027 fifo_winc and fifo_rinc SHALL never be asserted in a TURN state, and SHALL never be asserted in the same cycle.
REQ-028 tx_count SHALL increment on each fifo_winc and rx_count on each m_valid && m_ready; both SHALL wrap modulo 2^16 (0xFFFF -> 0x0000).
REQ-029 With dir_req held at 1, fifo_full SHALL only stall s_ready and SHALL NOT change state; fifo_empty in RX SHALL only stall fifo_rinc.

Reset
REQ-030 On rst_n low, the module SHALL reset asynchronously to: state RX, dir 0, busy 0, m_valid 0, output buffer empty, in-flight flag 0, guard counter 0, tx_count 0, rx_count 0.
REQ-031 During reset, s_ready, fifo_winc and fifo_rinc SHALL be 0.
REQ-032 Reset asserted mid-turnaround or mid-read SHALL discard buffered and in-flight data with no further m_valid.
REQ-033 Reset SHALL be released synchronously to clk by the integrator; the module SHALL be operational the first cycle after release.

Verification
REQ-034 Reset release with dir_req=0, fifo_empty=1 SHALL give dir=0, m_valid=0, fifo_rinc=0, and all counts 0.
REQ-035 RX stream: fifo_empty=0 for 3 words 0xA1,0xA2,0xA3 with m_ready=1 SHALL give rinc on 3 consecutive cycles, m_data A1,A2,A3 on consecutive cycles starting 2 cycles after the first rinc, and rx_count=3.
REQ-036 RX backpressure: m_ready=0 with 5 words available SHALL issue exactly 2 rincs and then hold m_data=first word; raising m_ready SHALL drain all 5 in order.
REQ-037 Turnaround with TURN_CYCLES=4: dir_req 0->1 while idle in RX SHALL give busy=1 for exactly 5 cycles, then dir=1, and s_ready=1 when fifo_full=0.
REQ-038 TX with fifo_full: 4 writes, with fifo_full asserted for 2 cycles after the 2nd, SHALL hold s_ready=0 for those cycles, give tx_count=4, and write no word twice.
REQ-039 Boundary cases: tx_count preset near 0xFFFF by 2 writes SHALL wrap to 0x0001; dir_req toggled 1->0 during TURN_R2T SHALL still reach TX, then immediately enter TURN_T2R.
